// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: round-robin arbitration between an ALU writeback (A)
// and a long-latency writeback (B), plus a per-register pending-write scoreboard.
module rf_wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          issue_v,
    input  logic [AW-1:0] issue_rd,
    output logic          issue_ok,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          busy1,
    output logic          busy2,
    input  logic          a_valid,
    input  logic [AW-1:0] a_rd,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_rd,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          we3,
    output logic [AW-1:0] a3,
    output logic [DW-1:0] wd3,
    output logic          sb_idle
);

    localparam int NREG = 2 ** AW;

    logic            r_last_b;
    logic            r_we3;
    logic [AW-1:0]   r_a3;
    logic [DW-1:0]   r_wd3;
    logic [NREG-1:0] r_busy;

    logic            w_grant_a;
    logic            w_grant_b;
    logic            w_accept;
    logic [AW-1:0]   w_rd;
    logic [DW-1:0]   w_data;
    logic            w_issue_ok;
    logic            w_set;
    logic [NREG-1:0] w_busy_nxt;

    // A wins a tie only when B was the last one granted.
    assign w_grant_a = a_valid && (!b_valid || r_last_b);
    assign w_grant_b = b_valid && !w_grant_a;
    assign w_accept  = w_grant_a || w_grant_b;
    assign w_rd      = w_grant_a ? a_rd : b_rd;
    assign w_data    = w_grant_a ? a_data : b_data;

    assign w_issue_ok = (issue_rd == '0) || !r_busy[issue_rd] ||
                        (r_we3 && (r_a3 == issue_rd));
    assign w_set      = issue_v && w_issue_ok && (issue_rd != '0);

    // The set is applied after the clear so a same-edge reissue keeps the bit high.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we3) begin
            w_busy_nxt[r_a3] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_b <= 1'b1;
            r_we3    <= 1'b0;
            r_a3     <= '0;
            r_wd3    <= '0;
            r_busy   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_accept) begin
                r_we3    <= (w_rd != '0);
                r_a3     <= w_rd;
                r_wd3    <= w_data;
                r_last_b <= w_grant_b;
            end else begin
                r_we3 <= 1'b0;
            end
        end
    end

    assign a_ready  = w_grant_a;
    assign b_ready  = w_grant_b;
    assign issue_ok = w_issue_ok;
    assign busy1    = (rs1 != '0) && r_busy[rs1];
    assign busy2    = (rs2 != '0) && r_busy[rs2];
    assign we3      = r_we3;
    assign a3       = r_a3;
    assign wd3      = r_wd3;
    assign sb_idle  = (r_busy == '0);

endmodule
